// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared pipeline types; instruction-cache address, frame and FSM types.
// Revision : 1.0
// ============================================================================
package cpu_types_pkg;

    // Default geometry: 16 frames of one 32-bit word each
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_frame_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_frame_array
// Brief    : Direct-mapped frame store; async read, single write, sync clear-all.
// Revision : 1.0
// ============================================================================
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [TAG_W-1:0] i_wtag,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    output logic             o_rvalid,
    output logic [TAG_W-1:0] o_rtag,
    output logic [31:0]      o_rdata
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    // Clear takes priority so an invalidate racing a fill leaves the frame invalid
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_rvalid = r_valid[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rdata  = r_data[i_ridx];

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_ctrl
// Brief    : Direct-mapped instruction cache controller with single-word fills.
// Revision : 1.0
// ============================================================================
module icache_ctrl
    import cpu_types_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [31:0]       imemload,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic              iwait,
    input  logic [31:0]       iload,
    input  logic              inval,
    output logic [PERF_W-1:0] hit_count,
    output logic [PERF_W-1:0] miss_count
);

    localparam int          c_IDX_W     = $clog2(SETS);
    localparam int          c_TAG_W     = 30 - c_IDX_W;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    icache_state_t     r_state;
    icache_state_t     w_next_state;
    logic [31:0]       r_miss_addr;
    logic [PERF_W-1:0] r_hit_count;
    logic [PERF_W-1:0] r_miss_count;

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_rd_valid;
    logic [c_TAG_W-1:0] w_rd_tag;
    logic [31:0]        w_rd_data;
    logic               w_lookup_hit;
    logic               w_miss_start;
    logic               w_fill_we;

    assign w_idx = imemaddr[c_IDX_W+1:2];
    assign w_tag = imemaddr[31:c_IDX_W+2];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (c_IDX_W),
        .TAG_W (c_TAG_W)
    ) u_frames (
        .clk      (CLK),
        .rst      (nRST),
        .i_clr    (inval),
        .i_we     (w_fill_we),
        .i_widx   (r_miss_addr[c_IDX_W+1:2]),
        .i_wtag   (r_miss_addr[31:c_IDX_W+2]),
        .i_wdata  (iload),
        .i_ridx   (w_idx),
        .o_rvalid (w_rd_valid),
        .o_rtag   (w_rd_tag),
        .o_rdata  (w_rd_data)
    );

    assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);

    always_comb begin
        w_next_state = r_state;
        ihit         = 1'b0;
        iREN         = 1'b0;
        w_miss_start = 1'b0;
        w_fill_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (imemREN && w_lookup_hit) begin
                    ihit = 1'b1;
                end else if (imemREN) begin
                    w_miss_start = 1'b1;
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                iREN = 1'b1;
                // Fill always lands at the latched miss address, whatever the fetch port shows now
                if (!iwait) begin
                    w_fill_we    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state      <= IDLE;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss_start) begin
                r_miss_addr  <= imemaddr;
                r_miss_count <= r_miss_count + PERF_W'(1);
            end
            if (ihit) begin
                r_hit_count <= r_hit_count + PERF_W'(1);
            end
        end
    end

    assign imemload   = w_rd_data;
    assign iaddr      = r_miss_addr & c_WORD_MASK;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_ctrl
// Brief    : Scoreboard bench for icache_ctrl against a word-address cache model.
// Revision : 1.0
// ============================================================================
module tb_icache_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
    logic        inval = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_ctrl #(.SETS(16), .PERF_W(32)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .inval      (inval),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] data;
        int          ren;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    bit          sb_on = 1'b0;
    int          cur_waits = 0;
    int          fcnt = 0;
    int          ren_cnt = 0;
    // Reference model: which word address each frame holds
    bit          mvalid [16];
    logic [31:0] mword  [16];
    logic [31:0] m_hit = 0;
    logic [31:0] m_miss = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    // Memory side: hold iwait for cur_waits FETCH cycles, then return the word
    initial forever begin
        @(negedge CLK);
        if (iREN) begin
            if (fcnt < cur_waits) begin
                iwait = 1'b1;
                fcnt++;
            end else begin
                iwait = 1'b0;
                iload = mem_word(iaddr);
            end
        end else begin
            iwait = 1'b1;
            fcnt  = 0;
        end
    end

    // Monitor: pops one expectation per ihit cycle
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (sb_on) begin
            if (iREN) begin
                ren_cnt++;
                if (sbq.size() > 0) chk("fill_iaddr", iaddr, sbq[0].waddr);
            end
            if (ihit) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ihit", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("imemload", imemload, e.data);
                    chk("fill_cycles", ren_cnt, e.ren);
                end
                ren_cnt = 0;
            end
        end else begin
            ren_cnt = 0;
        end
    end

    task automatic apply_reset();
        nRST = 1'b1; imemREN = 1'b0; inval = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b0;
        model_clear();
        m_hit = 0; m_miss = 0;
    endtask

    task automatic req(input logic [31:0] addr, input int waits, input int ncyc);
        logic [31:0] wa;
        int          idx;
        bit          hit;
        bit          got;
        exp_t        e;
        wa  = addr & 32'hFFFF_FFFC;
        idx = int'(wa[5:2]);
        hit = mvalid[idx] && (mword[idx] == wa);
        for (int i = 0; i < ncyc; i++) begin
            e.waddr = wa;
            e.data  = mem_word(wa);
            e.ren   = (i == 0 && !hit) ? waits + 1 : 0;
            sbq.push_back(e);
        end
        cur_waits = waits;
        @(posedge CLK); #1;
        imemaddr = addr;
        imemREN  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge CLK);
            if (ihit) got = 1'b1;
        end
        if (!got) begin
            chk("req_timeout", 0, 1);
            sbq.delete();
        end
        repeat (ncyc - 1) @(negedge CLK);
        @(posedge CLK); #1;
        imemREN = 1'b0;
        if (!hit) begin
            mvalid[idx] = 1'b1;
            mword[idx]  = wa;
            m_miss++;
        end
        m_hit += ncyc;
        @(negedge CLK);
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
    endtask

    task automatic do_inval();
        @(posedge CLK); #1;
        inval = 1'b1;
        @(posedge CLK); #1;
        inval = 1'b0;
        model_clear();
    endtask

    // Holds a request until ihit; returns FETCH cycles seen and the data delivered
    task automatic wait_hit(output int rens, output logic [31:0] data, output bit got);
        rens = 0; got = 1'b0; data = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge CLK);
            if (iREN) rens++;
            if (ihit) begin
                got  = 1'b1;
                data = imemload;
            end
        end
        if (!got) chk("wait_hit_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rens;
        logic [31:0] d;
        bit          got;

        apply_reset();
        @(negedge CLK);
        chk("rst_ihit", ihit, 0);
        chk("rst_iREN", iREN, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);

        // Cold miss, warm hits, conflict eviction
        sb_on = 1'b1;
        req(32'h40, 3, 1);
        req(32'h40, 0, 5);
        chk("warm_hit_count", hit_count, 6);
        req(32'h80, 1, 1);
        req(32'h40, 0, 1);

        // Address changes mid-fill
        sb_on = 1'b0;
        apply_reset();
        cur_waits = 2;
        imemaddr = 32'h100; imemREN = 1'b1;
        @(negedge CLK);
        chk("midfill_cycle0_ihit", ihit, 0);
        @(posedge CLK); #1;
        imemaddr = 32'h104;
        @(negedge CLK);
        chk("midfill_iaddr", iaddr, 32'h100);
        rens = 0;
        wait_hit(rens, d, got);
        chk("midfill_fetch_cycles", rens + 1, 6);
        chk("midfill_data", d, mem_word(32'h104));
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("midfill_miss_count", miss_count, 2);
        mvalid[0] = 1'b1; mword[0] = 32'h100;
        mvalid[1] = 1'b1; mword[1] = 32'h104;
        m_miss = 2; m_hit = 1;
        sb_on = 1'b1;
        req(32'h100, 0, 1);

        // Invalidate on the same edge as the fill
        sb_on = 1'b0;
        apply_reset();
        cur_waits = 1;
        @(posedge CLK); #1;
        imemaddr = 32'h200; imemREN = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("race_fill_cycle_iREN", iREN, 1);
        inval = 1'b1;
        @(posedge CLK); #1;
        inval = 1'b0;
        @(negedge CLK);
        chk("race_idle_iREN", iREN, 0);
        chk("race_reread_ihit", ihit, 0);
        wait_hit(rens, d, got);
        chk("race_refill_data", d, mem_word(32'h200));
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("race_miss_count", miss_count, 2);
        model_clear();
        mvalid[0] = 1'b1; mword[0] = 32'h200;
        m_miss = 2; m_hit = 1;

        // Reset while a fill is outstanding
        sb_on = 1'b1;
        req(32'h40, 0, 1);
        sb_on = 1'b0;
        cur_waits = 5;
        @(posedge CLK); #1;
        imemaddr = 32'h344; imemREN = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rstfetch_iREN_before", iREN, 1);
        nRST = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b0; imemREN = 1'b0;
        @(negedge CLK);
        chk("rstfetch_iREN_after", iREN, 0);
        chk("rstfetch_hit_count", hit_count, 0);
        chk("rstfetch_miss_count", miss_count, 0);
        model_clear();
        m_hit = 0; m_miss = 0;
        sb_on = 1'b1;
        req(32'h40, 0, 1);

        // Randomized traffic over a small address pool to force hits and conflicts
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) do_inval();
            req(a, $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
        end
        sb_on = 1'b0;
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
